// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the 2x2 max-pool stream controller.
package maxpool_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Register stages inside the external pooling unit (operands -> result).
    localparam int POOL_LAT = 1;

    // Counter width for a 0..depth-1 index; never narrower than one bit.
    function automatic int cnt_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/maxpool_linebuf.sv
// One-row line buffer: single write port, two combinational read ports.
// Contents are not reset; every location is rewritten on each even row
// before it is read on the following odd row.
module maxpool_linebuf #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr_a,
    input  logic [ADDR_W-1:0]     i_raddr_b,
    output logic [DATA_WIDTH-1:0] o_rdata_a,
    output logic [DATA_WIDTH-1:0] o_rdata_b
);

    logic [DATA_WIDTH-1:0] r_mem [IMG_W];

    // Store the accepted even-row pixel at its column.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/maxpool_stream_ctrl.sv
// Streams a raster feature map through an external registered 4-input max
// unit, one non-overlapping 2x2 window at a time, and emits pooled pixels on
// a valid/ready stream.
// Optional stall counter: define MAXPOOL_STREAM_CTRL_PERF_EN.
//
// state | meaning
// IDLE  | waiting for start, in_ready low
// RUN   | accepting pixels; window positions stall until pipeline/output free
// DRAIN | all pixels in; waiting for the last window to leave the output
// DONE  | one-cycle done pulse, then IDLE
module maxpool_stream_ctrl
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] pool_a,
    output logic [DATA_WIDTH-1:0] pool_b,
    output logic [DATA_WIDTH-1:0] pool_c,
    output logic [DATA_WIDTH-1:0] pool_d,
    input  logic [DATA_WIDTH-1:0] pool_result,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           perf_stall_cnt
);

    localparam int COL_W = cnt_width(IMG_W);
    localparam int ROW_W = cnt_width(IMG_H);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic                  r_v1;
    logic                  r_v2;
    logic [DATA_WIDTH-1:0] r_left_px;
    logic [DATA_WIDTH-1:0] r_pool_a;
    logic [DATA_WIDTH-1:0] r_pool_b;
    logic [DATA_WIDTH-1:0] r_pool_c;
    logic [DATA_WIDTH-1:0] r_pool_d;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;

    logic                  w_start_acc;
    logic                  w_win_pos;
    logic                  w_win_ok;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_col_last;
    logic                  w_row_last;
    logic [DATA_WIDTH-1:0] w_lb_left;
    logic [DATA_WIDTH-1:0] w_lb_right;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_win_pos   = r_row[0] && r_col[0];
    // A window may only enter when nothing is in flight and the output slot
    // will be free by the time the result lands; this caps throughput at one
    // window per three cycles but needs no result buffering.
    assign w_win_ok    = !r_v1 && !r_v2 && (!r_out_valid || out_ready);
    assign w_in_ready  = (r_state == RUN) && (!w_win_pos || w_win_ok);
    assign w_accept    = in_valid && w_in_ready;
    assign w_col_last  = (r_col == COL_W'(IMG_W - 1));
    assign w_row_last  = (r_row == ROW_W'(IMG_H - 1));

    maxpool_linebuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_W      (IMG_W),
        .ADDR_W     (COL_W)
    ) u_linebuf (
        .i_clk     (clk),
        .i_we      (w_accept && !r_row[0]),
        .i_waddr   (r_col),
        .i_wdata   (in_data),
        .i_raddr_a (r_col - COL_W'(1)),
        .i_raddr_b (r_col),
        .o_rdata_a (w_lb_left),
        .o_rdata_b (w_lb_right)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_accept && w_col_last && w_row_last) w_state_nxt = DRAIN;
            DRAIN:   if (!r_v1 && !r_v2 && !r_out_valid) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Hold the bottom-left pixel until its window partner arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_left_px <= '0;
        end else if (w_accept && r_row[0] && !r_col[0]) begin
            r_left_px <= in_data;
        end
    end

    // Window pipeline flags: v1 = operands presented, v2 = result being registered.
    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= w_accept && w_win_pos;
            r_v2 <= r_v1;
        end
    end

    // Register the four window operands; they hold between windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pool_a <= '0;
            r_pool_b <= '0;
            r_pool_c <= '0;
            r_pool_d <= '0;
        end else if (w_accept && w_win_pos) begin
            r_pool_a <= w_lb_left;
            r_pool_b <= w_lb_right;
            r_pool_c <= r_left_px;
            r_pool_d <= in_data;
        end
    end

    // Output slot: a fresh capture takes priority over a completing handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (r_v2) begin
            r_out_data  <= pool_result;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef MAXPOOL_STREAM_CTRL_PERF_EN
    logic [15:0] r_perf_cnt;

    // Count RUN cycles where upstream offers a pixel we refuse; saturates.
    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_perf_cnt <= '0;
        end else if ((r_state == RUN) && in_valid && !w_in_ready &&
                     (r_perf_cnt != 16'hFFFF)) begin
            r_perf_cnt <= r_perf_cnt + 16'd1;
        end
    end

    assign perf_stall_cnt = r_perf_cnt;
`else
    assign perf_stall_cnt = '0;
`endif

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign in_ready  = w_in_ready;
    assign pool_a    = r_pool_a;
    assign pool_b    = r_pool_b;
    assign pool_c    = r_pool_c;
    assign pool_d    = r_pool_d;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// Self-checking bench for maxpool_stream_ctrl on a 4x4 frame, with a
// behavioural pooling unit and a queue-based reference of window maxima.
module tb_maxpool_stream_ctrl;

    localparam int DW  = 8;
    localparam int W   = 4;
    localparam int H   = 4;
    localparam int NPX = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] pool_a, pool_b, pool_c, pool_d;
    logic [DW-1:0] pool_result = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   perf_stall_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] fpx [NPX];
    logic [DW-1:0] exp_q [$];
    int            lat_q [$];
    int            done_cnt = 0;
    int            pix_cnt = 0;
    int            wait_sum = 0;
    int            probe_idx = -1;
    int            mstart_idx = -1;
    bit            lat_en = 1'b0;
    int            ordy_mode = 0;
    int            ordy_rel = 0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;
    bit            ov_prev = 1'b0;

    maxpool_stream_ctrl #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .pool_a         (pool_a),
        .pool_b         (pool_b),
        .pool_c         (pool_c),
        .pool_d         (pool_d),
        .pool_result    (pool_result),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .perf_stall_cnt (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
        logic [DW-1:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Registered 4-input max unit, as the controller expects to drive.
    always @(posedge clk) pool_result <= max4(pool_a, pool_b, pool_c, pool_d);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Downstream ready policy: 0 always ready, 1 random, 2 held low until ordy_rel.
    always @(negedge clk) begin
        case (ordy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 1) == 1);
            default: out_ready = (cyc >= ordy_rel);
        endcase
    end

    // Output scoreboard, hold-stability, done counting and latency tracking.
    always @(negedge clk) begin
        int idx;
        #2;
        if (rst) begin
            stall_prev = 1'b0;
            ov_prev    = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (stall_prev) begin
                check_val("hold_valid", out_valid, 1);
                check_val("hold_data", out_data, hold_data);
            end
            stall_prev = out_valid && !out_ready;
            hold_data  = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_val("unexpected_out", out_data, 32'hFFFF_FFFF);
                else check_val("out_data", out_data, exp_q.pop_front());
            end
            if (lat_en) begin
                if (in_valid && in_ready) begin
                    idx = pix_cnt;
                    pix_cnt++;
                    if (((idx / W) % 2 == 1) && ((idx % W) % 2 == 1)) lat_q.push_back(cyc + 3);
                end
                if (out_valid && !ov_prev) begin
                    if (lat_q.size() == 0) check_val("latency_unexp", cyc, 0);
                    else check_val("latency", cyc, lat_q.pop_front());
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic send_px(input int idx, input logic [DW-1:0] d);
        int t;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        if (idx == mstart_idx) start = 1'b1;
        t = 0;
        #2;
        while (!in_ready && t < 200) begin
            if (idx == probe_idx && t == 3) begin
                check_val("probe_out_valid", out_valid, 1);
                check_val("probe_out_data", out_data, 5);
            end
            @(negedge clk);
            #2;
            t++;
        end
        if (t >= 200) check_val("px_timeout", idx, 32'hFFFF_FFFF);
        if (idx == probe_idx) check_val("probe_stall_len", (t >= 15), 1);
        wait_sum += t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_frame(input int gap_max, input int mode, input int rel, input bit lat);
        int t;
        int exp_perf;
        for (int wr = 0; wr < H / 2; wr++) begin
            for (int wc = 0; wc < W / 2; wc++) begin
                exp_q.push_back(max4(fpx[(2*wr)*W + 2*wc],   fpx[(2*wr)*W + 2*wc + 1],
                                     fpx[(2*wr+1)*W + 2*wc], fpx[(2*wr+1)*W + 2*wc + 1]));
            end
        end
        @(negedge clk);
        ordy_mode = mode;
        ordy_rel  = cyc + rel;
        done_cnt  = 0;
        pix_cnt   = 0;
        wait_sum  = 0;
        lat_en    = lat;
        lat_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        check_val("busy_after_start", busy, 1);
        for (int i = 0; i < NPX; i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_px(i, fpx[i]);
        end
        t = 0;
        while (done_cnt == 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check_val("done_seen", (t < 400), 1);
        #2;
        check_val("busy_after_done", busy, 0);
        repeat (3) @(negedge clk);
        #2;
        check_val("done_pulses", done_cnt, 1);
        check_val("exp_remaining", exp_q.size(), 0);
`ifdef MAXPOOL_STREAM_CTRL_PERF_EN
        exp_perf = wait_sum;
`else
        exp_perf = 0;
`endif
        check_val("perf_stall_cnt", perf_stall_cnt, exp_perf);
        lat_en = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_pool_a", pool_a, 0);
        check_val("rst_pool_d", pool_d, 0);
        check_val("rst_perf", perf_stall_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Ascending frame, always ready, latency tracked.
        for (int i = 0; i < NPX; i++) fpx[i] = DW'(i);
        run_frame(0, 0, 0, 1'b1);

        // Ascending frame, downstream blocked for 30 cycles.
        probe_idx = 7;
        run_frame(0, 2, 30, 1'b0);
        probe_idx = -1;

        // Descending and all-equal frames.
        for (int i = 0; i < NPX; i++) fpx[i] = DW'(NPX - 1 - i);
        run_frame(0, 0, 0, 1'b1);
        for (int i = 0; i < NPX; i++) fpx[i] = 8'hAA;
        run_frame(0, 0, 0, 1'b1);

        // Abort after six pixels; the in-flight window must vanish.
        @(negedge clk);
        ordy_mode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) send_px(i, DW'($urandom_range(0, 255)));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_val("abort_busy", busy, 0);
        check_val("abort_out_valid", out_valid, 0);
        check_val("abort_in_ready", in_ready, 0);
        check_val("abort_perf", perf_stall_cnt, 0);
        repeat (6) @(negedge clk);
        for (int i = 0; i < NPX; i++) fpx[i] = DW'(i);
        run_frame(0, 0, 0, 1'b1);

        // start pulsed mid-frame is ignored.
        mstart_idx = 9;
        run_frame(1, 1, 0, 1'b0);
        mstart_idx = -1;

        // Back-to-back pixels with a long downstream stall.
        for (int i = 0; i < NPX; i++) fpx[i] = DW'($urandom_range(0, 255));
        run_frame(0, 2, 12, 1'b0);

        // Random frames with random gaps and random downstream readiness.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NPX; i++) fpx[i] = DW'($urandom_range(0, 255));
            run_frame(2, 1, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
